// File: rtl/execute_operand_stage.sv
// ============================================================================
// Module      : execute_operand_stage
// Description : Resolves SrcA/SrcB/WriteData with MEM/WB forwarding and
//               holds them in a valid/ready register feeding execute.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   RD1,
    input  logic [XLEN-1:0]   RD2,
    input  logic [XLEN-1:0]   ImmExt,
    input  logic [XLEN-1:0]   PC,
    input  logic [REG_AW-1:0] Rs1,
    input  logic [REG_AW-1:0] Rs2,
    input  logic [1:0]        ALUSrcA,
    input  logic              ALUSrc,
    input  logic              mem_fwd_en,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_fwd_en,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   SrcA,
    output logic [XLEN-1:0]   SrcB,
    output logic [XLEN-1:0]   WriteData,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_AW-1:0] c_X0      = '0;
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

    logic [XLEN-1:0]  w_fwd_a;
    logic [XLEN-1:0]  w_fwd_b;
    logic [XLEN-1:0]  w_src_a;
    logic [XLEN-1:0]  w_src_b;
    logic             w_load;

    logic             r_valid;
    logic [XLEN-1:0]  r_src_a;
    logic [XLEN-1:0]  r_src_b;
    logic [XLEN-1:0]  r_wdata;
    logic [CNT_W-1:0] r_stall_cnt;

    // MEM is the younger producer, so it wins over WB; x0 always reads RF.
    always_comb begin
        w_fwd_a = RD1;
        if (mem_fwd_en && (mem_fwd_rd == Rs1) && (Rs1 != c_X0))
            w_fwd_a = mem_fwd_data;
        else if (wb_fwd_en && (wb_fwd_rd == Rs1) && (Rs1 != c_X0))
            w_fwd_a = wb_fwd_data;
    end

    always_comb begin
        w_fwd_b = RD2;
        if (mem_fwd_en && (mem_fwd_rd == Rs2) && (Rs2 != c_X0))
            w_fwd_b = mem_fwd_data;
        else if (wb_fwd_en && (wb_fwd_rd == Rs2) && (Rs2 != c_X0))
            w_fwd_b = wb_fwd_data;
    end

    always_comb begin
        w_src_a = w_fwd_a;
        case (ALUSrcA)
            2'b01:   w_src_a = PC;
            2'b10:   w_src_a = '0;
            default: w_src_a = w_fwd_a;
        endcase
    end

    assign w_src_b  = ALUSrc ? ImmExt : w_fwd_b;
    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_src_a     <= '0;
            r_src_b     <= '0;
            r_wdata     <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush)
                r_valid <= 1'b0;
            else if (w_load)
                r_valid <= 1'b1;
            else if (out_ready)
                r_valid <= 1'b0;

            // Operands are sampled only on an accept, so a hold freezes them.
            if (w_load) begin
                r_src_a <= w_src_a;
                r_src_b <= w_src_b;
                r_wdata <= w_fwd_b;
            end

            if (r_valid && !out_ready && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid = r_valid;
    assign SrcA      = r_src_a;
    assign SrcB      = r_src_b;
    assign WriteData = r_wdata;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_execute_operand_stage.sv
// Directed bench for execute_operand_stage; a second instance with a
// 3-bit stall counter shares all inputs to exercise saturation.
`default_nettype none

module tb_execute_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready, ir2;
    logic [31:0] RD1, RD2, ImmExt, PC;
    logic [4:0]  Rs1, Rs2;
    logic [1:0]  ALUSrcA;
    logic        ALUSrc;
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        flush;
    logic        out_valid, v2;
    logic        out_ready;
    logic [31:0] SrcA, SrcB, WriteData, sa2, sb2, wd2;
    logic [15:0] stall_cnt;
    logic [2:0]  cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    execute_operand_stage #(.XLEN(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt), .PC(PC), .Rs1(Rs1), .Rs2(Rs2),
        .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .WriteData(WriteData), .stall_cnt(stall_cnt)
    );

    execute_operand_stage #(.XLEN(32), .REG_AW(5), .CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
        .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt), .PC(PC), .Rs1(Rs1), .Rs2(Rs2),
        .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .out_valid(v2), .out_ready(out_ready),
        .SrcA(sa2), .SrcB(sb2), .WriteData(wd2), .stall_cnt(cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; out_ready = 1; flush = 0;
        RD1 = 0; RD2 = 0; ImmExt = 0; PC = 0; Rs1 = 0; Rs2 = 0;
        ALUSrcA = 2'b00; ALUSrc = 0;
        mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        in_valid = 1; RD1 = 32'h55; flush = 1;
        step();
        step();
        reset = 0; in_valid = 0; flush = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (SrcA !== 0 || SrcB !== 0 || WriteData !== 0) begin n_err++; $display("FAIL reset_data got=%h/%h/%h exp=0", SrcA, SrcB, WriteData); end
        n_cmp++; if (stall_cnt !== 0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_srcb();
        do_reset();
        RD2 = 32'h11; ImmExt = 32'h22; Rs2 = 5'd3; in_valid = 1; ALUSrc = 0;
        step();
        n_cmp++; if (out_valid !== 1'b1 || SrcB !== 32'h11) begin n_err++; $display("FAIL srcb_reg got=%0b/%h exp=1/11", out_valid, SrcB); end
        n_cmp++; if (WriteData !== 32'h11) begin n_err++; $display("FAIL srcb_wd0 got=%h exp=11", WriteData); end
        ALUSrc = 1;
        step();
        n_cmp++; if (SrcB !== 32'h22) begin n_err++; $display("FAIL srcb_imm got=%h exp=22", SrcB); end
        n_cmp++; if (WriteData !== 32'h11) begin n_err++; $display("FAIL srcb_wd1 got=%h exp=11", WriteData); end
        in_valid = 0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL srcb_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_forwarding();
        do_reset();
        in_valid = 1; Rs1 = 5'd5; RD1 = 32'h1234; ALUSrcA = 2'b00;
        mem_fwd_en = 1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hAAAA;
        wb_fwd_en = 1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'hBBBB;
        step();
        n_cmp++; if (SrcA !== 32'hAAAA) begin n_err++; $display("FAIL fwd_mem_prio got=%h exp=aaaa", SrcA); end
        mem_fwd_en = 0;
        step();
        n_cmp++; if (SrcA !== 32'hBBBB) begin n_err++; $display("FAIL fwd_wb got=%h exp=bbbb", SrcA); end
        wb_fwd_en = 0;
        step();
        n_cmp++; if (SrcA !== 32'h1234) begin n_err++; $display("FAIL fwd_rf got=%h exp=1234", SrcA); end
        Rs2 = 5'd0; RD2 = 0; mem_fwd_en = 1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hDEAD;
        wb_fwd_en = 1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'hBEEF; ALUSrc = 0;
        step();
        n_cmp++; if (WriteData !== 0 || SrcB !== 0) begin n_err++; $display("FAIL fwd_x0 got=%h/%h exp=0", WriteData, SrcB); end
        Rs2 = 5'd7; RD2 = 32'h70; mem_fwd_en = 0; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h77;
        step();
        n_cmp++; if (WriteData !== 32'h77) begin n_err++; $display("FAIL fwd_wb_b got=%h exp=77", WriteData); end
        in_valid = 0; wb_fwd_en = 0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1; out_ready = 0; Rs1 = 5'd1; RD1 = 32'h100; Rs2 = 5'd2; RD2 = 32'h200;
        step();
        mem_fwd_en = 1; mem_fwd_rd = 5'd1; mem_fwd_data = 32'h999;
        wb_fwd_en = 1; wb_fwd_rd = 5'd2; wb_fwd_data = 32'h888;
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (SrcA !== 32'h100 || SrcB !== 32'h200) begin n_err++; $display("FAIL bp_hold got=%h/%h exp=100/200", SrcA, SrcB); end
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_ready got=%0b/%0b exp=0/1", in_ready, out_valid); end
        n_cmp++; if (stall_cnt !== 16'd4) begin n_err++; $display("FAIL bp_cnt got=%0d exp=4", stall_cnt); end
        out_ready = 1; mem_fwd_en = 0; wb_fwd_en = 0; RD1 = 32'h300; RD2 = 32'h400;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_consume got=%0b exp=1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || SrcA !== 32'h300 || SrcB !== 32'h400) begin n_err++; $display("FAIL bp_b2b got=%0b/%h/%h exp=1/300/400", out_valid, SrcA, SrcB); end
        n_cmp++; if (stall_cnt !== 16'd4) begin n_err++; $display("FAIL bp_cnt_after got=%0d exp=4", stall_cnt); end
        in_valid = 0;
        step();
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1; out_ready = 0; Rs1 = 5'd1; RD1 = 32'h10;
        step();
        flush = 1; RD1 = 32'h20;
        step();
        flush = 0; in_valid = 0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_hold got=%0b/%0b exp=0/1", out_valid, in_ready); end
        n_cmp++; if (SrcA !== 32'h10) begin n_err++; $display("FAIL flush_nocapture got=%h exp=10", SrcA); end
        in_valid = 1; out_ready = 1; RD1 = 32'h30;
        step();
        flush = 1; RD1 = 32'h40;
        step();
        flush = 0; in_valid = 0;
        n_cmp++; if (out_valid !== 1'b0 || SrcA !== 32'h30) begin n_err++; $display("FAIL flush_consume got=%0b/%h exp=0/30", out_valid, SrcA); end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1; out_ready = 0; RD1 = 32'h5A; Rs1 = 5'd9;
        step();
        in_valid = 0;
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (cnt2 !== 3'd5) begin n_err++; $display("FAIL sat_mid got=%0d exp=5", cnt2); end
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (cnt2 !== 3'd7) begin n_err++; $display("FAIL sat_hold got=%0d exp=7", cnt2); end
        n_cmp++; if (stall_cnt !== 16'd10) begin n_err++; $display("FAIL sat_wide got=%0d exp=10", stall_cnt); end
        reset = 1;
        step();
        reset = 0;
        n_cmp++; if (cnt2 !== 0 || v2 !== 1'b0 || sa2 !== 0 || sb2 !== 0 || wd2 !== 0) begin n_err++; $display("FAIL sat_reset got=%0d/%0b/%h/%h/%h exp=0", cnt2, v2, sa2, sb2, wd2); end
        out_ready = 1;
    endtask

    task automatic test_srca_modes();
        do_reset();
        in_valid = 1; PC = 32'h1000; RD1 = 32'h5; Rs1 = 5'd4;
        ALUSrcA = 2'b01;
        step();
        n_cmp++; if (SrcA !== 32'h1000) begin n_err++; $display("FAIL srca_pc got=%h exp=1000", SrcA); end
        ALUSrcA = 2'b10;
        step();
        n_cmp++; if (SrcA !== 32'h0) begin n_err++; $display("FAIL srca_zero got=%h exp=0", SrcA); end
        ALUSrcA = 2'b00;
        step();
        n_cmp++; if (SrcA !== 32'h5) begin n_err++; $display("FAIL srca_rd1 got=%h exp=5", SrcA); end
        ALUSrcA = 2'b11; RD1 = 32'h6;
        step();
        n_cmp++; if (SrcA !== 32'h6) begin n_err++; $display("FAIL srca_11 got=%h exp=6", SrcA); end
        in_valid = 0;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1; ALUSrc = 1;
        for (int i = 0; i < 3; i++) begin
            ImmExt = 32'hC0 + i;
            step();
            n_cmp++; if (out_valid !== 1'b1 || SrcB !== 32'hC0 + i) begin n_err++; $display("FAIL b2b_%0d got=%0b/%h exp=1/%h", i, out_valid, SrcB, 32'hC0 + i); end
        end
        in_valid = 0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || stall_cnt !== 0) begin n_err++; $display("FAIL b2b_end got=%0b/%0d exp=0/0", out_valid, stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_srcb();
        test_forwarding();
        test_backpressure();
        test_flush();
        test_saturation();
        test_srca_modes();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/execute_operand_stage.md
# execute_operand_stage

Parametrised successor to the execute-stage SrcB select. Resolves both ALU operands (SrcA, SrcB) and store data with MEM/WB forwarding, then registers them in a valid/ready pipeline register between decode and execute. Provides stall and flush handling and a saturating stall-cycle counter. Sits at the decode→execute boundary of the pipelined core.

## Interface

**Parameters**

- `XLEN`, 32, datapath width.
- `REG_AW`, 5, register-address width.
- `CNT_W`, 16, stall counter width.

**Ports**

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage can accept.
- `RD1`, `RD2`  in  XLEN  register-file read data.
- `ImmExt`  in  XLEN  extended immediate.
- `PC`  in  XLEN  instruction PC.
- `Rs1`, `Rs2`  in  REG_AW  source register addresses.
- `ALUSrcA`  in  2  00 = forwarded RD1, 01 = PC, 10 = zero, 11 = forwarded RD1.
- `ALUSrc`  in  1  0 = forwarded RD2, 1 = ImmExt (selects SrcB).
- `mem_fwd_en`  in  1  MEM stage writes a register.
- `mem_fwd_rd`  in  REG_AW  MEM destination register.
- `mem_fwd_data`  in  XLEN  MEM result.
- `wb_fwd_en`, `wb_fwd_rd`, `wb_fwd_data`  in  1 / REG_AW / XLEN  same signals for WB.
- `flush`  in  1  kill the held and the incoming instruction.
- `out_valid`  out  1  registered operands valid.
- `out_ready`  in  1  execute consumes.
- `SrcA`, `SrcB`, `WriteData`  out  XLEN  registered operands; WriteData is the forwarded RD2.
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`.

## Operation

**Forwarding (combinational, per source)**

- Use MEM when `mem_fwd_en && mem_fwd_rd == Rs && Rs != 0`.
- Otherwise use WB when the equivalent WB condition holds.
- Otherwise use the register-file value.
- MEM has priority over WB. Register x0 is never forwarded.

**Selection**

- SrcA per `ALUSrcA`.
- SrcB = `ALUSrc ? ImmExt : fwdB`.
- WriteData = fwdB, independent of `ALUSrc`.

**Handshake**

- `in_ready = !out_valid || out_ready`.
- Load: `in_valid && in_ready && !flush` captures SrcA, SrcB and WriteData, and sets `out_valid`.
- `out_valid && out_ready` with no new load clears `out_valid`.
- Held operands stay frozen while `out_valid && !out_ready`. Forwarding values that change during a hold are not re-sampled.

**Flush**

- Next cycle `out_valid = 0`, regardless of `in_valid` or `out_ready`.
- Data registers may hold stale values.

**Counter**

- `stall_cnt` increments each cycle with `out_valid && !out_ready`.
- Saturates at 2^CNT_W − 1. Cleared only by reset.

**Width rules**

- All muxing is XLEN-wide. No sign or zero manipulation. PC is passed as-is.

## Timing

- Reset (synchronous): `out_valid = 0`, `SrcA = SrcB = WriteData = 0`, `stall_cnt = 0`.
  - `in_ready` reads 1 in the cycle after reset deasserts.
  - Reset overrides flush and load.
  - Reset mid-stall discards the held instruction.
- Latency: 1 cycle from accepted input to `out_valid`. Throughput: 1 per cycle with `out_ready` held high.
- Simultaneous consume and load: `out_valid` stays 1 and the registers take the new operands; no bubble.
- Simultaneous flush and consume: the consume is honoured for the current beat; next cycle `out_valid = 0`.
- Forwarding is sampled at the accept edge only.
- Counter saturation: at the maximum value the counter holds with no wrap.

## Test plan

1. **Basic SrcB select**
   - Stimulus: RD2 = 0x11, ImmExt = 0x22; accept with `ALUSrc = 0`, then `ALUSrc = 1`, `out_ready = 1`.
   - Required: SrcB = 0x11, then 0x22, one cycle after each accept. `WriteData = 0x11` both times.
2. **Forwarding priority and x0**
   - Stimulus: Rs1 = 5, MEM rd = 5 data 0xAAAA, WB rd = 5 data 0xBBBB.
   - Required: SrcA = 0xAAAA. With MEM disabled, SrcA = 0xBBBB.
   - Stimulus: Rs2 = 0 with MEM rd = 0 enabled, RD2 = 0.
   - Required: WriteData = 0.
3. **Backpressure hold**
   - Stimulus: accept op A, `out_ready = 0` for 4 cycles, change forwarding data meanwhile.
   - Required: SrcA/SrcB unchanged, `in_ready = 0`, `stall_cnt = 4`.
   - Then `out_ready = 1` together with `in_valid`.
   - Required: next op B loads the same edge that A is consumed.
4. **Flush**
   - Stimulus: `out_valid = 1`, `out_ready = 0`; assert `flush` together with `in_valid`.
   - Required: next cycle `out_valid = 0`, `in_ready = 1`, nothing captured.
5. **Counter saturation with CNT_W = 3**
   - Stimulus: stall for 10 cycles.
   - Required: `stall_cnt = 7`, held.
   - Stimulus: reset.
   - Required: `stall_cnt = 0`, `out_valid = 0`, all operand outputs 0.
6. **SrcA modes**
   - Stimulus: PC = 0x1000, RD1 = 0x5; `ALUSrcA` = 01, 10, 00 in turn.
   - Required: SrcA = 0x1000, 0, 0x5.
